frame_scheduler: RTL
====================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter NUM_PIXELS, default 64; pixels per frame on an 8x8 matrix.
REQ-002 Parameter LATCH_CYCLES, default 3600; low-time between frames (300 us at 12 MHz).
REQ-003 Parameter FRAME_CYCLES, default 400000; minimum frame-start-to-frame-start period (30 Hz at 12 MHz).
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 init_done  input  1  high when all three colour memories are loaded.
REQ-007 row  output  3  matrix row address of pixel being fetched.
REQ-008 col  output  3  matrix column address of pixel being fetched.
REQ-009 red, green, blue  input  8 each  pixel channels; valid one cycle after row/col change.
REQ-010 shift  input  1  per-bit pulse from ws2812b driver.
REQ-011 load_sreg  output  1  one-cycle pulse; loads pixel_value into shift register.
REQ-012 pixel_value  output  24  packed pixel, {green, red, blue}, MSB first on the wire.
REQ-013 transmit_pixel  output  1  enables ws2812b driver.
REQ-014 frame_done  output  1  one-cycle pulse at end of latch gap.

Function
REQ-015 States SHALL be IDLE, FETCH, LOAD, SEND, LATCH, HOLD.
REQ-016 IDLE -> FETCH when init_done=1; pixel index cleared to 0; init_done sampled only in IDLE.
REQ-017 FETCH: row/col SHALL present pixel index (row=idx[5:3], col=idx[2:0]); one cycle, then LOAD.
REQ-018 LOAD: pixel_value SHALL capture {green,red,blue}; load_sreg high exactly this cycle; next state SEND.
REQ-019 SEND: transmit_pixel high; 5-bit bit counter increments per shift pulse; after 24th pulse -> FETCH (idx+1) or LATCH if idx=NUM_PIXELS-1.
REQ-020 transmit_pixel SHALL drop in the cycle after the 24th shift; FETCH/LOAD gap is 2 cycles with transmit_pixel low.
REQ-021 LATCH: transmit_pixel low for exactly LATCH_CYCLES cycles; frame_done pulses in the last LATCH cycle; next HOLD.
REQ-022 Frame timer starts at 0 on each FETCH of pixel 0, saturates at FRAME_CYCLES-1.
REQ-023 HOLD -> FETCH (idx=0) when frame timer saturated; if already saturated on entry, HOLD lasts one cycle.
REQ-024 shift pulses outside SEND SHALL be ignored; counters never wrap past their terminal values.
REQ-025 Pixel index width $clog2(NUM_PIXELS); wraps to 0 only via LATCH->HOLD->FETCH.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, idx=0, bit/latch/frame counters=0, pixel_value=0, load_sreg=0, transmit_pixel=0, frame_done=0, row=col=0.
REQ-027 Reset mid-SEND SHALL abort the pixel; next frame restarts at pixel 0 after init_done.

Configuration
REQ-028 Macro SERPENTINE_EN defined: odd rows SHALL output col = 7 - idx[2:0]; even rows unchanged.
REQ-029 SERPENTINE_EN undefined: col = idx[2:0] for all rows (progressive scan).

Structure
REQ-030 Package led_pkg SHALL hold state enum, NUM_PIXELS default, BITS_PER_PIXEL=24, GRB packing function.
REQ-031 One sub-module, frame_timer (loadable saturating counter), SHALL implement both latch and frame counters as two instances.

Verification
REQ-032 Bench uses LATCH_CYCLES=10, FRAME_CYCLES=2000, shift model pulsing every 4 cycles while transmit_pixel high.
REQ-033 init_done=0 for 50 cycles -> load_sreg, transmit_pixel stay 0; init_done=1 -> first load_sreg 2 cycles later, row=col=0.
REQ-034 Pixel 0 red=8'h11, green=8'h22, blue=8'h33 -> pixel_value=24'h221133 in load_sreg cycle.
REQ-035 Full frame -> exactly 64 load_sreg pulses, 1536 shift pulses counted, transmit_pixel low 10 cycles, one frame_done; next pixel-0 FETCH at 2000 cycles after previous.
REQ-036 SERPENTINE_EN defined, idx=8..15 -> col sequence 7,6,...,0 on row 1; undefined -> 0..7.
REQ-037 rst_n=0 during SEND of pixel 20 -> all outputs 0 next cycle; after release, first load_sreg shows pixel 0 data.
REQ-038 Extra shift pulses injected during LATCH/HOLD -> no state change, latch duration still 10 cycles.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame scheduler.
package led_pkg;

    localparam int NUM_PIXELS_DEF = 64;
    localparam int BITS_PER_PIXEL = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        LATCH = 3'd4,
        HOLD  = 3'd5
    } state_t;

    // ws2812b wants green first, then red, then blue, MSB first
    function automatic logic [BITS_PER_PIXEL-1:0] pack_grb(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {g, r, b};
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Saturating up-counter with synchronous clear; sat_o is high while the count sits at MAX_COUNT.
module frame_timer #(
    parameter int MAX_COUNT = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic sat_o
);
    localparam int CW = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

    logic [CW-1:0] count_q, count_d;

    assign sat_o = (count_q == MAX_C);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !sat_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Walks the pixel memory, hands GRB words to the ws2812b driver and paces frames.
// Build option: SERPENTINE_EN reverses column order on odd rows.
//
//   state | meaning
//   IDLE  | waiting for colour memories to be loaded
//   FETCH | row/col present pixel address to memory
//   LOAD  | memory data valid; load shift register
//   SEND  | driver shifting 24 bits out
//   LATCH | line held low so the strip latches the frame
//   HOLD  | waiting for the minimum frame period to elapse
module frame_scheduler
    import led_pkg::*;
#(
    parameter int NUM_PIXELS   = NUM_PIXELS_DEF,
    parameter int LATCH_CYCLES = 3600,
    parameter int FRAME_CYCLES = 400000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_done,
    output logic [2:0]                row,
    output logic [2:0]                col,
    input  logic [7:0]                red,
    input  logic [7:0]                green,
    input  logic [7:0]                blue,
    input  logic                      shift,
    output logic                      load_sreg,
    output logic [BITS_PER_PIXEL-1:0] pixel_value,
    output logic                      transmit_pixel,
    output logic                      frame_done
);
    localparam int IW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PIXELS - 1);
    localparam logic [4:0]    LAST_BIT = 5'(BITS_PER_PIXEL - 1);

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4:0]                bit_q, bit_d;
    logic [BITS_PER_PIXEL-1:0] pix_q, pix_d;
    logic                      frame_start;
    logic                      latch_sat;
    logic                      frame_sat;
    logic [5:0]                addr;

    assign addr = 6'(idx_q);
    assign row  = addr[5:3];
`ifdef SERPENTINE_EN
    assign col  = addr[3] ? (3'd7 - addr[2:0]) : addr[2:0];
`else
    assign col  = addr[2:0];
`endif

    // Held at zero outside LATCH, so the first LATCH cycle reads count 0
    frame_timer #(.MAX_COUNT(LATCH_CYCLES - 1)) u_latch_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_q != LATCH),
        .en_i    (1'b1),
        .sat_o   (latch_sat)
    );

    frame_timer #(.MAX_COUNT(FRAME_CYCLES - 1)) u_frame_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (frame_start),
        .en_i    (1'b1),
        .sat_o   (frame_sat)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bit_d       = bit_q;
        pix_d       = pix_q;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_done) begin
                    state_d     = FETCH;
                    idx_d       = '0;
                    frame_start = 1'b1;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                pix_d   = pack_grb(red, green, blue);
                bit_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (shift) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = LATCH;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
            end
            LATCH: begin
                if (latch_sat) state_d = HOLD;
            end
            HOLD: begin
                if (frame_sat) begin
                    state_d     = FETCH;
                    idx_d       = '0;
                    frame_start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
        end
    end

    // Memory data is only valid during LOAD, so the driver sees it directly on that edge
    assign pixel_value    = (state_q == LOAD) ? pack_grb(red, green, blue) : pix_q;
    assign load_sreg      = (state_q == LOAD);
    assign transmit_pixel = (state_q == SEND);
    assign frame_done     = (state_q == LATCH) && latch_sat;

endmodule
